// File: rtl/mmio_param_fifo_if.sv
// Push/pop handshake and status bundle for mmio_param_fifo.
// master: the side that pushes, pops and flushes; slave: the FIFO itself.
interface mmio_param_fifo_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
);
    logic                         clr;
    logic                         push;
    logic [WIDTH-1:0]             d;
    logic                         pop;
    logic [WIDTH-1:0]             q;
    logic                         q_valid;
    logic                         full;
    logic                         empty;
    logic                         almost_full;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         overflow;
    logic                         underflow;

    modport master (
        output clr, push, d, pop,
        input  q, q_valid, full, empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  clr, push, d, pop,
        output q, q_valid, full, empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/mmio_param_fifo.sv
// Parametrised circular-buffer FIFO between the MMIO write and read paths.
// Independent push/pop handshakes, occupancy, almost-full, sticky
// overflow/underflow flags and a synchronous flush (clr).
// Build option: define MMIO_FIFO_FWFT_EN for first-word fall-through reads;
// left undefined, reads are registered (q loads one cycle after an accepted pop).
module mmio_param_fifo #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mmio_param_fifo_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             full_w;
    logic             empty_w;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + PW'(1);
    endfunction

    // Flags come only from the registered count, never from push/pop.
    always_comb begin
        full_w  = (count_r == DEPTH_C);
        empty_w = (count_r == '0);
        pop_ok  = bus.pop & ~empty_w;
        push_ok = bus.push & (~full_w | pop_ok);
    end

    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.almost_full = (count_r >= AF_C);
    assign bus.count       = count_r;
    assign bus.overflow    = overflow_r;
    assign bus.underflow   = underflow_r;

    // Storage write; not reset, a dropped push leaves it untouched.
    always_ff @(posedge clk) begin
        if (!bus.clr && push_ok) begin
            mem[wr_ptr] <= bus.d;
        end
    end

    // Pointers, occupancy and sticky error flags; clr beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_next(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
            if (bus.push && !push_ok) overflow_r  <= 1'b1;
            if (bus.pop  && !pop_ok)  underflow_r <= 1'b1;
        end
    end

`ifdef MMIO_FIFO_FWFT_EN
    // Head word is always presented; pop only acknowledges it.
    assign bus.q       = mem[rd_ptr];
    assign bus.q_valid = ~empty_w;
`else
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;

    // Registered read: head word lands on q the cycle after an accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else if (bus.clr) begin
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= pop_ok;
            if (pop_ok) q_r <= mem[rd_ptr];
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
`endif
endmodule
